// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RV32M multiply/divide unit with a busy/done handshake
module muldiv_unit #(
  parameter int XLEN = 32,
  parameter bit FAST_MUL = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;
  localparam int CW = $clog2(XLEN + 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic [2:0] f3;
  logic neg;
  logic [XLEN-1:0] opd;
  logic [2*XLEN-1:0] acc;
  logic is_div, sgn_a, sgn_b, neg_a, neg_b, new_neg, div0, ovf, special;
  logic [XLEN-1:0] mag_a, mag_b, spec_res;
  logic [XLEN:0] mul_sum;
  logic [XLEN+1:0] diff;
  logic [2*XLEN-1:0] mul_nxt, div_nxt, nxt, fast_p;
  // Sign-fix a magnitude product or {remainder, quotient} pair and pick the requested half.
  function automatic logic [XLEN-1:0] fin(input logic [2*XLEN-1:0] p, input logic [2:0] f, input logic n);
    logic [2*XLEN-1:0] sp;
    logic [XLEN-1:0] v;
    sp = n ? -p : p;
    v = f[1] ? p[2*XLEN-1:XLEN] : p[XLEN-1:0];
    return f[2] ? (n ? -v : v) : (f[1:0] == 2'b00 ? sp[XLEN-1:0] : sp[2*XLEN-1:XLEN]);
  endfunction
  assign is_div = funct3[2];
  assign sgn_a = is_div ? !funct3[0] : funct3[1:0] != 2'b11;
  assign sgn_b = is_div ? !funct3[0] : !funct3[1];
  assign neg_a = sgn_a & op_a[XLEN-1];
  assign neg_b = sgn_b & op_b[XLEN-1];
  assign mag_a = neg_a ? -op_a : op_a;
  assign mag_b = neg_b ? -op_b : op_b;
  assign new_neg = (is_div && funct3[1]) ? neg_a : neg_a ^ neg_b;
  assign div0 = is_div && op_b == '0;
  assign ovf = is_div && !funct3[0] && op_a == {1'b1, {(XLEN-1){1'b0}}} && &op_b;
  assign special = div0 || ovf || (!is_div && FAST_MUL);
  assign fast_p = (2*XLEN)'(mag_a) * (2*XLEN)'(mag_b);
  assign spec_res = div0 ? (funct3[1] ? op_a : '1) : ovf ? (funct3[1] ? '0 : op_a) : fin(fast_p, funct3, new_neg);
  // Shift-add keeps the multiplier in the low half; restoring divide keeps the quotient there.
  assign mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opd} : '0);
  assign mul_nxt = {mul_sum, acc[XLEN-1:1]};
  assign diff = {1'b0, acc[2*XLEN-1:XLEN-1]} - {2'b00, opd};
  assign div_nxt = {diff[XLEN+1] ? acc[2*XLEN-2:XLEN-1] : diff[XLEN-1:0], acc[XLEN-2:0], !diff[XLEN+1]};
  assign nxt = state == DIV ? div_nxt : mul_nxt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      f3 <= '0;
      neg <= 1'b0;
      opd <= '0;
      acc <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      result <= '0;
    end else if (flush) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
    end else if (state == MUL || state == DIV) begin
      acc <= nxt;
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        state <= FIN;
        busy <= 1'b0;
        done <= 1'b1;
        result <= fin(nxt, f3, neg);
      end
    end else if (start) begin
      f3 <= funct3;
      neg <= new_neg;
      opd <= is_div ? mag_b : mag_a;
      acc <= {{XLEN{1'b0}}, is_div ? mag_a : mag_b};
      cnt <= CW'(XLEN);
      state <= special ? FIN : is_div ? DIV : MUL;
      busy <= !special;
      done <= special;
      if (special) result <= spec_res;
    end else begin
      state <= IDLE;
      done <= 1'b0;
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vector table plus handshake, flush and reset sequences
module tb_muldiv_unit;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, flush = 1'b0;
  logic [2:0] funct3 = '0;
  logic [31:0] op_a = '0, op_b = '0;
  logic busy0, done0, busy1, done1;
  logic [31:0] result0, result1;
  int vecs = 0, errs = 0;
  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e;
    int          lat;
  } vec_t;
  vec_t tbl[16];

  muldiv_unit #(.XLEN(32), .FAST_MUL(1'b0)) u_slow (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3), .op_a(op_a), .op_b(op_b),
    .flush(flush), .busy(busy0), .done(done0), .result(result0));
  muldiv_unit #(.XLEN(32), .FAST_MUL(1'b1)) u_fast (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3), .op_a(op_a), .op_b(op_b),
    .flush(flush), .busy(busy1), .done(done1), .result(result1));

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic launch(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    funct3 = f;
    op_a = a;
    op_b = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int n, output int nb);
    n = 1;
    nb = 0;
    while (!done0 && n < 100) begin
      if (busy0) nb++;
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int n, nb, nd, dn;
    logic [31:0] rs;
    tbl[0]  = '{3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33};
    tbl[1]  = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33};
    tbl[2]  = '{3'b011, 32'h80000000, 32'h80000000, 32'h40000000, 33};
    tbl[3]  = '{3'b010, 32'h80000000, 32'h80000000, 32'hC0000000, 33};
    tbl[4]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
    tbl[5]  = '{3'b000, 32'h12345678, 32'h00000010, 32'h23456780, 33};
    tbl[6]  = '{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33};
    tbl[7]  = '{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33};
    tbl[8]  = '{3'b101, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, 33};
    tbl[9]  = '{3'b111, 32'hFFFFFFF9, 32'd2,        32'h00000001, 33};
    tbl[10] = '{3'b100, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 33};
    tbl[11] = '{3'b110, 32'd100,      32'hFFFFFFF9, 32'h00000002, 33};
    tbl[12] = '{3'b101, 32'h00001234, 32'd0,        32'hFFFFFFFF, 1};
    tbl[13] = '{3'b110, 32'h00001234, 32'd0,        32'h00001234, 1};
    tbl[14] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    tbl[15] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1};

    repeat (2) @(negedge clk);
    check("reset busy", {31'b0, busy0}, 32'd0);
    check("reset done", {31'b0, done0}, 32'd0);
    check("reset result", result0, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      launch(tbl[i].f, tbl[i].a, tbl[i].b);
      if (!tbl[i].f[2]) begin
        check($sformatf("v%0d fast done", i), {31'b0, done1}, 32'd1);
        check($sformatf("v%0d fast busy", i), {31'b0, busy1}, 32'd0);
        check($sformatf("v%0d fast result", i), result1, tbl[i].e);
      end
      wait_done(n, nb);
      check($sformatf("v%0d result", i), result0, tbl[i].e);
      check($sformatf("v%0d latency", i), n, tbl[i].lat);
      check($sformatf("v%0d busy cycles", i), nb, tbl[i].lat == 1 ? 0 : 32);
    end

    // start during an active divide must be ignored
    launch(3'b100, 32'd100, 32'd7);
    nd = 0;
    dn = 0;
    rs = '0;
    for (int k = 1; k <= 80; k++) begin
      if (done0) begin
        nd++;
        rs = result0;
        dn = k;
      end
      start = (k == 5);
      if (k == 5) begin
        funct3 = 3'b101;
        op_a = 32'd0;
        op_b = 32'd3;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("ignored start done count", nd, 1);
    check("ignored start result", rs, 32'd14);
    check("ignored start latency", dn, 33);

    // back-to-back: new start in the done cycle
    launch(3'b000, 32'd7, 32'd3);
    wait_done(n, nb);
    check("b2b first result", result0, 32'd21);
    start = 1'b1;
    funct3 = 3'b000;
    op_a = 32'd5;
    op_b = 32'd6;
    @(negedge clk);
    start = 1'b0;
    wait_done(n, nb);
    check("b2b second latency", n, 33);
    check("b2b second result", result0, 32'd30);

    // flush mid-multiply
    launch(3'b000, 32'd9, 32'd9);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush busy", {31'b0, busy0}, 32'd0);
    check("flush done", {31'b0, done0}, 32'd0);
    check("flush result", result0, 32'd30);
    nd = 0;
    for (int k = 0; k < 40; k++) begin
      if (done0) nd++;
      @(negedge clk);
    end
    check("flush no done", nd, 0);

    // asynchronous reset mid-divide
    launch(3'b100, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    check("pre-reset busy", {31'b0, busy0}, 32'd1);
    rst = 1'b1;
    #1;
    check("async reset busy", {31'b0, busy0}, 32'd0);
    check("async reset done", {31'b0, done0}, 32'd0);
    check("async reset result", result0, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
